// File: rtl/fifo_mp.sv
// -----------------------------------------------------------------------------
// fifo_mp
//   Multi-port circular FIFO for superscalar fetch/dispatch queues.
//   Up to PUSH_W entries may be enqueued and up to POP_W entries dequeued
//   in one cycle. All 2^DEPTH_POW2 entries are usable because the head and
//   tail pointers carry an extra wrap bit. The read side is show-ahead: the
//   oldest POP_W entries are always presented combinationally, and a pop
//   consumes what is presented in that same cycle.
//
// Ports
//   clk_i          system clock
//   reset_i        asynchronous active-low reset (pointers and error flags)
//   flush_i        synchronous clear of all entries, highest priority
//   push_cnt_i     number of lanes of write_data_i to enqueue this cycle
//   write_data_i   PUSH_W lanes, lane 0 is oldest in program order
//   pop_cnt_i      number of entries to dequeue this cycle
//   read_data_o    POP_W lanes, lane k = entry at head+k
//   read_valid_o   bit k set when lane k holds a live entry
//   count_o        occupied entries
//   free_o         unoccupied entries
//   full_o         queue full
//   empty_o        queue empty
//   almost_full_o  count_o >= AFULL_THRESH
//   overflow_o     one-cycle pulse after a rejected push
//   underflow_o    one-cycle pulse after a rejected pop
// -----------------------------------------------------------------------------
module fifo_mp #(
    parameter int WIDTH        = 32,
    parameter int DEPTH_POW2   = 3,
    parameter int PUSH_W       = 2,
    parameter int POP_W        = 2,
    parameter int AFULL_THRESH = 6
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             flush_i,
    input  logic [$clog2(PUSH_W+1)-1:0]      push_cnt_i,
    input  logic [PUSH_W-1:0][WIDTH-1:0]     write_data_i,
    input  logic [$clog2(POP_W+1)-1:0]       pop_cnt_i,
    output logic [POP_W-1:0][WIDTH-1:0]      read_data_o,
    output logic [POP_W-1:0]                 read_valid_o,
    output logic [DEPTH_POW2:0]              count_o,
    output logic [DEPTH_POW2:0]              free_o,
    output logic                             full_o,
    output logic                             empty_o,
    output logic                             almost_full_o,
    output logic                             overflow_o,
    output logic                             underflow_o
);

    localparam int DEPTH = 1 << DEPTH_POW2;
    localparam int PTR_W = DEPTH_POW2 + 1;

    typedef logic [PTR_W-1:0]      ptr_t;
    typedef logic [DEPTH_POW2-1:0] idx_t;

    // -------------------------------------------------------------------------
    // Parameter sanity, caught at elaboration
    // -------------------------------------------------------------------------
    if (DEPTH_POW2 < 1) begin : g_bad_depth
        $error("fifo_mp: DEPTH_POW2 must be >= 1");
    end
    if (PUSH_W < 1 || PUSH_W > (1 << DEPTH_POW2)) begin : g_bad_push_w
        $error("fifo_mp: PUSH_W must be in 1..2^DEPTH_POW2");
    end
    if (POP_W < 1 || POP_W > (1 << DEPTH_POW2)) begin : g_bad_pop_w
        $error("fifo_mp: POP_W must be in 1..2^DEPTH_POW2");
    end
    if (AFULL_THRESH > (1 << DEPTH_POW2)) begin : g_bad_afull
        $error("fifo_mp: AFULL_THRESH must be <= 2^DEPTH_POW2");
    end

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    // Storage index of the entry 'off' places after pointer 'base'. The
    // addition runs on the full pointer width and the wrap bit is dropped,
    // so multi-entry accesses split across the last index naturally.
    function automatic idx_t slot(input ptr_t base, input int off);
        ptr_t sum;
        sum = base + ptr_t'(off);
        return sum[DEPTH_POW2-1:0];
    endfunction

    // All-or-nothing acceptance: a request fits only if it is within the
    // lane limit and within the room available at the start of the cycle.
    // Out-of-range counts are therefore rejected rather than corrupting the
    // pointers.
    function automatic logic fits(input int req, input int lane_max, input int room);
        return (req <= lane_max) && (req <= room);
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] r_mem [DEPTH];
    ptr_t             r_head;
    ptr_t             r_tail;
    logic             r_overflow;
    logic             r_underflow;

    ptr_t             w_count;
    ptr_t             w_free;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic             w_push_do;
    logic [PUSH_W-1:0] w_lane_we;

    // -------------------------------------------------------------------------
    // Occupancy and acceptance
    // -------------------------------------------------------------------------
    assign w_count = r_tail - r_head;
    assign w_free  = ptr_t'(DEPTH) - w_count;

    // Push is judged against free space before any same-cycle pop, so a pop
    // never makes room for a push in the same cycle.
    assign w_push_ok = fits(int'(push_cnt_i), PUSH_W, int'(w_free));
    assign w_pop_ok  = fits(int'(pop_cnt_i), POP_W, int'(w_count));
    assign w_push_do = w_push_ok && !flush_i;

    always_comb begin
        w_lane_we = '0;
        for (int k = 0; k < PUSH_W; k++) begin
            w_lane_we[k] = w_push_do && (k < int'(push_cnt_i));
        end
    end

    // -------------------------------------------------------------------------
    // Pointer and error-flag registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush_i) begin
            // Flush discards any push/pop in the same cycle and raises no error.
            r_head      <= '0;
            r_tail      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_pop_ok) begin
                r_head <= r_head + ptr_t'(pop_cnt_i);
            end
            if (w_push_ok) begin
                r_tail <= r_tail + ptr_t'(push_cnt_i);
            end
            // A zero count always fits, so these only fire on real rejections.
            r_overflow  <= !w_push_ok;
            r_underflow <= !w_pop_ok;
        end
    end

    // -------------------------------------------------------------------------
    // Entry storage (not reset; contents only matter once pushed)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < PUSH_W; k++) begin
            if (w_lane_we[k]) begin
                r_mem[slot(r_tail, k)] <= write_data_i[k];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Show-ahead read path, straight from registers (no write bypass)
    // -------------------------------------------------------------------------
    always_comb begin
        read_data_o  = '0;
        read_valid_o = '0;
        for (int k = 0; k < POP_W; k++) begin
            read_data_o[k]  = r_mem[slot(r_head, k)];
            read_valid_o[k] = (k < int'(w_count));
        end
    end

    assign count_o       = w_count;
    assign free_o        = w_free;
    assign full_o        = (w_count == ptr_t'(DEPTH));
    assign empty_o       = (w_count == '0);
    assign almost_full_o = (int'(w_count) >= AFULL_THRESH);
    assign overflow_o    = r_overflow;
    assign underflow_o   = r_underflow;

    // -------------------------------------------------------------------------
    // Illegal request counts
    // -------------------------------------------------------------------------
    always @(posedge clk_i) begin
        if (reset_i) begin
            assert (int'(push_cnt_i) <= PUSH_W)
            else $error("fifo_mp: push_cnt_i=%0d exceeds PUSH_W=%0d", push_cnt_i, PUSH_W);
            assert (int'(pop_cnt_i) <= POP_W)
            else $error("fifo_mp: pop_cnt_i=%0d exceeds POP_W=%0d", pop_cnt_i, POP_W);
        end
    end

endmodule
